// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]  HEADER   = 8'hA5;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam int unsigned WL_W     = 9;

endpackage

// File: rtl/instr_store.sv
// DEPTH x 32 instruction store: one synchronous write port, one asynchronous read port.
module instr_store #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    // No reset: contents must survive rst and failed frames.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_loader.sv
// Framed, checksummed byte-stream loader for the CPU instruction store; holds the
// CPU in reset until a complete frame has been received and verified.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter logic [7:0]  HEADER   = loader_pkg::HEADER,
    parameter logic [31:0] NOP_WORD = loader_pkg::NOP_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(DEPTH)-1:0] rom_address,
    output logic [31:0]              rom_data,
    output logic                     cpu_reset,
    output logic                     cpu_enable,
    output logic                     load_error,
    output logic [WL_W-1:0]          words_loaded
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic            r_cpu_reset;
    logic            r_cpu_enable;
    logic            r_load_error;
    logic [WL_W-1:0] r_words_loaded;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_lane;
    logic [7:0]      r_sum;
    logic [WL_W-1:0] r_n;
    logic [WL_W-1:0] r_wcnt;
    logic [23:0]     r_word;
    logic            w_accept;
    logic            w_we;
    logic [31:0]     w_rd_data;

    assign w_accept = in_valid && r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame completion is judged on the word count; r_addr wraps for a full 256-word frame.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_accept && in_data == HEADER) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_accept) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_accept && r_lane == 2'd3) begin
                    w_we = 1'b1;
                    if (r_wcnt + WL_W'(1) == r_n) w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_accept) w_state_nxt = (in_data == r_sum) ? S_DONE : S_ERROR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready     <= 1'b0;
            r_cpu_reset    <= 1'b1;
            r_cpu_enable   <= 1'b0;
            r_load_error   <= 1'b0;
            r_words_loaded <= '0;
            r_addr         <= '0;
            r_lane         <= '0;
            r_sum          <= '0;
            r_n            <= '0;
            r_wcnt         <= '0;
            r_word         <= '0;
        end else begin
            r_in_ready   <= 1'b1;
            r_cpu_reset  <= (w_state_nxt != S_DONE);
            r_cpu_enable <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                case (r_state)
                    S_LEN: begin
                        r_n          <= (in_data == 8'd0) ? WL_W'(DEPTH) : WL_W'(in_data);
                        r_addr       <= '0;
                        r_lane       <= '0;
                        r_sum        <= '0;
                        r_wcnt       <= '0;
                        r_load_error <= 1'b0;
                    end
                    S_DATA: begin
                        r_sum  <= r_sum + in_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0:    r_word[7:0]   <= in_data;
                            2'd1:    r_word[15:8]  <= in_data;
                            2'd2:    r_word[23:16] <= in_data;
                            default: begin
                                r_addr <= r_addr + AW'(1);
                                r_wcnt <= r_wcnt + WL_W'(1);
                            end
                        endcase
                    end
                    S_CHECK: begin
                        if (in_data == r_sum) r_words_loaded <= r_n;
                        else                  r_load_error   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    instr_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata ({in_data, r_word}),
        .i_raddr (rom_address),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        rom_data = (r_state == S_DONE) ? w_rd_data : NOP_WORD;
    end

    assign in_ready     = r_in_ready;
    assign cpu_reset    = r_cpu_reset;
    assign cpu_enable   = r_cpu_enable;
    assign load_error   = r_load_error;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame loading, checksum failure, restart, wrap and reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  rom_address;
    logic [31:0] rom_data;
    logic        cpu_reset;
    logic        cpu_enable;
    logic        load_error;
    logic [8:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    program_loader #(
        .DEPTH    (256),
        .HEADER   (8'hA5),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .cpu_reset    (cpu_reset),
        .cpu_enable   (cpu_enable),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_wait got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic read_word(input logic [7:0] a, input logic [31:0] exp, input string name);
        rom_address = a;
        #1;
        total++;
        if (rom_data !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, rom_data, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; rom_address = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (cpu_reset !== 1'b1)    begin bad++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
        total++; if (cpu_enable !== 1'b0)   begin bad++; $display("FAIL rst_cpu_enable got=%b exp=0", cpu_enable); end
        total++; if (load_error !== 1'b0)   begin bad++; $display("FAIL rst_load_error got=%b exp=0", load_error); end
        total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL rst_words_loaded got=%0d exp=0", words_loaded); end
        total++; if (rom_data !== 32'h13)   begin bad++; $display("FAIL rst_rom_data got=%h exp=00000013", rom_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1)     begin bad++; $display("FAIL in_ready_rise got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] f [6] = '{8'hA5, 8'h01, 8'h13, 8'h05, 8'h10, 8'h00};
        foreach (f[i]) send_byte(f[i]);
        total++; if (cpu_enable !== 1'b0)   begin bad++; $display("FAIL basic_pre_enable got=%b exp=0", cpu_enable); end
        read_word(8'h00, 32'h0000_0013, "basic_pre_rom");
        send_byte(8'h28);
        total++; if (cpu_enable !== 1'b1)   begin bad++; $display("FAIL basic_enable got=%b exp=1", cpu_enable); end
        total++; if (cpu_reset !== 1'b0)    begin bad++; $display("FAIL basic_reset got=%b exp=0", cpu_reset); end
        total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL basic_words got=%0d exp=1", words_loaded); end
        total++; if (load_error !== 1'b0)   begin bad++; $display("FAIL basic_err got=%b exp=0", load_error); end
        read_word(8'h00, 32'h0010_0513, "basic_rom0");
    endtask

    task automatic test_bad_checksum();
        logic [7:0] f [7] = '{8'hA5, 8'h01, 8'h13, 8'h05, 8'h10, 8'h00, 8'h29};
        logic [7:0] g [5] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
        foreach (f[i]) send_byte(f[i]);
        total++; if (load_error !== 1'b1)   begin bad++; $display("FAIL bad_err got=%b exp=1", load_error); end
        total++; if (cpu_reset !== 1'b1)    begin bad++; $display("FAIL bad_reset got=%b exp=1", cpu_reset); end
        total++; if (cpu_enable !== 1'b0)   begin bad++; $display("FAIL bad_enable got=%b exp=0", cpu_enable); end
        total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL bad_words got=%0d exp=1", words_loaded); end
        read_word(8'h00, 32'h0000_0013, "bad_rom_nop");
        send_byte(8'hA5);
        send_byte(8'h01);
        total++; if (load_error !== 1'b0)   begin bad++; $display("FAIL err_clear got=%b exp=0", load_error); end
        foreach (g[i]) send_byte(g[i]);
        total++; if (cpu_enable !== 1'b1)   begin bad++; $display("FAIL resend_enable got=%b exp=1", cpu_enable); end
        read_word(8'h00, 32'h0010_0513, "resend_rom0");
    endtask

    task automatic test_restart_noise();
        logic [7:0] g [6] = '{8'h01, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
        send_byte(8'h00);
        send_byte(8'hFF);
        total++; if (cpu_enable !== 1'b1)   begin bad++; $display("FAIL noise_enable got=%b exp=1", cpu_enable); end
        read_word(8'h00, 32'h0010_0513, "noise_rom0");
        send_byte(8'hA5);
        total++; if (cpu_enable !== 1'b0)   begin bad++; $display("FAIL restart_enable got=%b exp=0", cpu_enable); end
        total++; if (cpu_reset !== 1'b1)    begin bad++; $display("FAIL restart_reset got=%b exp=1", cpu_reset); end
        read_word(8'h00, 32'h0000_0013, "restart_rom_nop");
        foreach (g[i]) send_byte(g[i]);
        total++; if (cpu_enable !== 1'b1)   begin bad++; $display("FAIL restart_done got=%b exp=1", cpu_enable); end
    endtask

    task automatic test_full();
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
        end
        total++; if (cpu_enable !== 1'b0)     begin bad++; $display("FAIL full_pre_enable got=%b exp=0", cpu_enable); end
        send_byte(8'h80);
        total++; if (words_loaded !== 9'd256) begin bad++; $display("FAIL full_words got=%0d exp=256", words_loaded); end
        total++; if (dut.r_addr !== 8'd0)     begin bad++; $display("FAIL full_addr_wrap got=%0d exp=0", dut.r_addr); end
        total++; if (cpu_enable !== 1'b1)     begin bad++; $display("FAIL full_enable got=%b exp=1", cpu_enable); end
        read_word(8'hFF, 32'h0000_00FF, "full_rom255");
        read_word(8'h80, 32'h0000_0080, "full_rom128");
        read_word(8'h00, 32'h0000_0000, "full_rom0");
    endtask

    task automatic test_reset_mid();
        logic [7:0] f [8] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] g [7] = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        foreach (f[i]) send_byte(f[i]);
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
        total++; if (cpu_enable !== 1'b0)   begin bad++; $display("FAIL mid_enable got=%b exp=0", cpu_enable); end
        total++; if (cpu_reset !== 1'b1)    begin bad++; $display("FAIL mid_reset got=%b exp=1", cpu_reset); end
        total++; if (words_loaded !== 9'd0) begin bad++; $display("FAIL mid_words got=%0d exp=0", words_loaded); end
        total++; if (rom_data !== 32'h13)   begin bad++; $display("FAIL mid_rom got=%h exp=00000013", rom_data); end
        total++; if (dut.u_store.r_mem[0] !== 32'h4433_2211) begin
            bad++; $display("FAIL mid_word0 got=%h exp=44332211", dut.u_store.r_mem[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        foreach (g[i]) send_byte(g[i]);
        total++; if (words_loaded !== 9'd1) begin bad++; $display("FAIL mid_reload_words got=%0d exp=1", words_loaded); end
        read_word(8'h00, 32'h1234_5678, "mid_rom0");
        read_word(8'h01, 32'h0000_0001, "mid_rom1_kept");
        read_word(8'h02, 32'h0000_0002, "mid_rom2_kept");
    endtask

    // 3-word frame with A5 inside the data; checksum 0xF0.
    task automatic run_frame3(input bit gaps, input string tag);
        logic [7:0] f [15] = '{8'hA5, 8'h03, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE,
                               8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hF0};
        for (int i = 0; i < 15; i++) begin
            if (gaps) begin
                in_data = 8'hA5;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            if (i == 14) begin
                total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL %s_pre_enable got=%b exp=0", tag, cpu_enable); end
            end
            send_byte(f[i]);
        end
        total++; if (cpu_enable !== 1'b1)   begin bad++; $display("FAIL %s_enable got=%b exp=1", tag, cpu_enable); end
        total++; if (words_loaded !== 9'd3) begin bad++; $display("FAIL %s_words got=%0d exp=3", tag, words_loaded); end
        read_word(8'h00, 32'h0000_00A5, {tag, "_rom0"});
        read_word(8'h01, 32'hDEAD_BEEF, {tag, "_rom1"});
        read_word(8'h02, 32'h0000_0013, {tag, "_rom2"});
    endtask

    task automatic test_gapped();
        run_frame3(1'b1, "gapped");
        run_frame3(1'b0, "gapfree");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_restart_noise();
        test_full();
        test_reset_mid();
        test_gapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
